paddle_ctrl: RTL and testbench

PADDLE_CTRL -- requirements
Module: paddle_ctrl

---
 rtl/paddle_ctrl_if.sv | 14 +
 rtl/paddle_ctrl.sv | 125 ++++++++++++
 tb/tb_paddle_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/paddle_ctrl_if.sv
// Joystick-in / paddle-out bundle for paddle_ctrl; clock and reset stay plain ports.
interface paddle_ctrl_if;
    logic       frame_tick;
    logic [9:0] joy_y;
    logic [1:0] joy_btn;
    logic [9:0] paddle_y;
    logic       paddle_valid;
    logic       serve;

    modport master (output frame_tick, joy_y, joy_btn,
                    input  paddle_y, paddle_valid, serve);
    modport slave  (input  frame_tick, joy_y, joy_btn,
                    output paddle_y, paddle_valid, serve);
endinterface

// File: rtl/paddle_ctrl.sv
// Purpose: per-frame joystick-to-paddle position controller with deadzone, boost and serve edge detect.
// Latency: paddle_y/paddle_valid/serve update 3 clocks after the clock that samples frame_tick.
// Backpressure: none; frame_tick is only accepted in IDLE. PADDLE_SMOOTH_EN adds a 4-sample joy_y average.
module paddle_ctrl #(
    parameter int SCREEN_H  = 480,
    parameter int PADDLE_H  = 64,
    parameter int CENTER    = 512,
    parameter int DEADZONE  = 64,
    parameter int MAX_SPEED = 8
) (
    input  logic           clk50M,
    input  logic           rst_n,
    paddle_ctrl_if.slave   io
);
    localparam logic [9:0]  Y_MAX   = 10'(SCREEN_H - PADDLE_H);
    localparam logic [9:0]  Y_RST   = 10'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [11:0] SPD_MAX = 12'(MAX_SPEED);
    localparam logic [11:0] SPD_BST = 12'(2 * MAX_SPEED);

    typedef enum logic [1:0] {IDLE, CAPTURE, COMPUTE, APPLY} state_t;

    state_t      state;
    logic [1:0]  cap_btn;
    logic        btn0_prev;
    logic [11:0] spd;
    logic        up;
    logic [9:0]  y_q;
    logic        vld_q;
    logic        serve_q;
    logic [9:0]  sample;

`ifdef PADDLE_SMOOTH_EN
    logic [9:0]  hist [4];
    logic [11:0] hist_sum;

    assign hist_sum = 12'(hist[0]) + 12'(hist[1]) + 12'(hist[2]) + 12'(hist[3]);
    assign sample   = 10'(hist_sum >> 2);
`else
    logic [9:0]  cap_y;

    assign sample = cap_y;
`endif

    logic signed [10:0] d;
    logic [10:0]        abs_d;
    logic [11:0]        base;
    logic [11:0]        spd_next;

    always_comb begin
        d        = $signed({1'b0, sample}) - $signed(11'(CENTER));
        abs_d    = d[10] ? 11'(-d) : 11'(d);
        base     = 12'((abs_d - 11'(DEADZONE)) >> 5) + 12'd1;
        if (base > SPD_MAX) base = SPD_MAX;
        spd_next = '0;
        if (abs_d > 11'(DEADZONE)) begin
            if (cap_btn[1]) spd_next = ((base << 1) > SPD_BST) ? SPD_BST : (base << 1);
            else            spd_next = base;
        end
    end

    // Position is widened to signed 12 bits so an overshoot past either edge clamps instead of wrapping.
    logic signed [11:0] pos;
    logic [9:0]         y_next;

    always_comb begin
        pos = up ? ($signed({2'b00, y_q}) - $signed(spd))
                 : ($signed({2'b00, y_q}) + $signed(spd));
        if (pos < 12'sd0)                          y_next = '0;
        else if (pos > $signed({2'b00, Y_MAX}))    y_next = Y_MAX;
        else                                       y_next = pos[9:0];
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cap_btn   <= '0;
            btn0_prev <= 1'b0;
            spd       <= '0;
            up        <= 1'b0;
            y_q       <= Y_RST;
            vld_q     <= 1'b0;
            serve_q   <= 1'b0;
`ifdef PADDLE_SMOOTH_EN
            for (int i = 0; i < 4; i++) hist[i] <= 10'(CENTER);
`else
            cap_y     <= '0;
`endif
        end else begin
            vld_q   <= 1'b0;
            serve_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (io.frame_tick) state <= CAPTURE;
                end
                CAPTURE: begin
                    cap_btn   <= io.joy_btn;
                    btn0_prev <= cap_btn[0];
`ifdef PADDLE_SMOOTH_EN
                    hist[0] <= io.joy_y;
                    for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
`else
                    cap_y   <= io.joy_y;
`endif
                    state <= COMPUTE;
                end
                COMPUTE: begin
                    spd   <= spd_next;
                    up    <= (d > 11'sd0);
                    state <= APPLY;
                end
                APPLY: begin
                    y_q     <= y_next;
                    vld_q   <= 1'b1;
                    serve_q <= cap_btn[0] & ~btn0_prev;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.paddle_y     = y_q;
    assign io.paddle_valid = vld_q;
    assign io.serve        = serve_q;
endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed frames push expected paddle_y/serve/arrival-cycle into a queue; a negedge monitor pops on paddle_valid.
`timescale 1ns/1ps
module tb_paddle_ctrl;
    logic clk50M = 1'b0;
    logic rst_n;
    always #10 clk50M = ~clk50M;

    paddle_ctrl_if pif();
    paddle_ctrl dut (.clk50M(clk50M), .rst_n(rst_n), .io(pif));

    typedef struct {
        int   y;
        int   srv;
        int   cyc;
    } exp_t;

    exp_t expq[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk50M) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk50M) begin
        if (pif.paddle_valid) begin
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: paddle_y=%0d serve=%0d, no update expected (t=%0t)",
                         pif.paddle_y, pif.serve, $time);
            end else begin
                e = expq.pop_front();
                check("paddle_y", int'(pif.paddle_y), e.y);
                check("serve",    int'(pif.serve),    e.srv);
                check("latency_cycle", cyc, e.cyc);
            end
        end else if (pif.serve) begin
            tests++;
            fails++;
            $display("FAIL serve_without_valid: serve=1 paddle_valid=0 (t=%0t)", $time);
        end
    end

    task automatic do_reset();
        @(posedge clk50M); #1;
        rst_n = 1'b0;
        pif.frame_tick = 1'b0;
        repeat (2) @(posedge clk50M);
        #1;
        check("rst_paddle_y", int'(pif.paddle_y), 208);
        check("rst_valid", int'(pif.paddle_valid), 0);
        check("rst_serve", int'(pif.serve), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk50M);
        #1;
    endtask

    // One frame: tick is sampled at edge E; the update must be visible after edge E+3.
    task automatic frame(input logic [9:0] jy, input logic [1:0] jb, input int ey, input int es,
                         input bit tick_in_compute = 1'b0, input bit rst_in_apply = 1'b0);
        @(posedge clk50M); #1;
        pif.joy_y      = jy;
        pif.joy_btn    = jb;
        pif.frame_tick = 1'b1;
        @(posedge clk50M); #1;
        pif.frame_tick = 1'b0;
        if (!rst_in_apply) expq.push_back('{y: ey, srv: es, cyc: cyc + 3});
        @(posedge clk50M); #1;
        if (tick_in_compute) pif.frame_tick = 1'b1;
        @(posedge clk50M); #1;
        pif.frame_tick = 1'b0;
        if (rst_in_apply) rst_n = 1'b0;
        @(posedge clk50M); #1;
        if (rst_in_apply) begin
            check("apply_rst_paddle_y", int'(pif.paddle_y), 208);
            check("apply_rst_valid", int'(pif.paddle_valid), 0);
            check("apply_rst_serve", int'(pif.serve), 0);
            rst_n = 1'b1;
            repeat (3) @(posedge clk50M);
            #1;
        end
    endtask

    initial begin
        #200us;
        $display("FAIL timeout: simulation exceeded time limit, %0d expected updates pending", expq.size());
        $fatal(1, "timeout");
    end

    initial begin
        rst_n          = 1'b0;
        pif.frame_tick = 1'b0;
        pif.joy_y      = 10'd512;
        pif.joy_btn    = 2'b00;

        do_reset();
        frame(10'd512, 2'b00, 208, 0);

`ifndef PADDLE_SMOOTH_EN
        for (int k = 1; k <= 28; k++)
            frame(10'd1023, 2'b00, (208 - 8*k < 0) ? 0 : 208 - 8*k, 0);

        do_reset();
        for (int k = 1; k <= 15; k++)
            frame(10'd0, 2'b10, (208 + 16*k > 416) ? 416 : 208 + 16*k, 0);

        do_reset();
        frame(10'd600, 2'b00, 207, 0);
        frame(10'd560, 2'b00, 207, 0);
        frame(10'd576, 2'b00, 207, 0);
        frame(10'd577, 2'b00, 206, 0);
        frame(10'd400, 2'b00, 208, 0);
        frame(10'd448, 2'b00, 208, 0);
`endif

        do_reset();
        for (int k = 0; k < 5; k++) frame(10'd512, 2'b01, 208, (k == 0) ? 1 : 0);
        frame(10'd512, 2'b00, 208, 0);
        frame(10'd512, 2'b01, 208, 1);
        frame(10'd512, 2'b01, 208, 0);
        frame(10'd512, 2'b00, 208, 0);

        do_reset();
`ifdef PADDLE_SMOOTH_EN
        frame(10'd1023, 2'b00, 206, 0, 1'b1, 1'b0);
`else
        frame(10'd1023, 2'b00, 200, 0, 1'b1, 1'b0);
`endif
        repeat (6) @(posedge clk50M);
        #1;
        frame(10'd1023, 2'b00, 0, 0, 1'b0, 1'b1);
        repeat (6) @(posedge clk50M);
        #1;
        frame(10'd512, 2'b00, 208, 0);

        repeat (8) @(posedge clk50M);
        #1;
        check("pending_expected", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
